// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch-stage state encoding and shared defaults
package instr_fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, ERR = 2'd3} state_t;
  localparam int PC_INC_DEFAULT = 1;
  localparam int OPC_W = 2;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, decode/control and PC signals of the fetch stage
interface instr_fetch_if #(parameter int AW = 8, parameter int IW = 16);
  logic imem_req;
  logic [AW-1:0] imem_addr;
  logic imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr;
  logic instr_valid;
  logic instr_ready;
  logic pc_src;
  logic [AW-1:0] branch_offset;
  logic [AW-1:0] pc;
  logic fetch_err;
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, fetch_err,
    input imem_ack, imem_rdata, instr_ready, pc_src, branch_offset
  );
  modport slave (
    input imem_req, imem_addr, instr, instr_valid, pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, pc_src, branch_offset
  );
endinterface

// File: rtl/instr_fetch_pc_next_logic.sv
// instr_fetch_pc_next_logic: next-PC select, sequential step or two's-complement branch, modulo 2^AW
module instr_fetch_pc_next_logic import instr_fetch_pkg::*; #(
  parameter int AW = 8,
  parameter int PC_INC = PC_INC_DEFAULT
) (
  input  logic [AW-1:0] pc,
  input  logic          pc_src,
  input  logic [AW-1:0] branch_offset,
  output logic [AW-1:0] pc_next
);
  assign pc_next = pc + (pc_src ? branch_offset : AW'(PC_INC));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches over req/ack and holds the instruction until the core commits it
module instr_fetch import instr_fetch_pkg::*; #(
  parameter int AW = 8,
  parameter int IW = 16,
  parameter int RESET_PC = 0,
  parameter int PC_INC = PC_INC_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);
  state_t state, state_n;
  logic [AW-1:0] pc, pc_next;
  logic [IW-1:0] instr;
  logic instr_valid, fetch_err;
  logic [7:0] cnt;
  logic ack, commit, expire;
  assign ack = state == REQ && bus.imem_ack;
  assign commit = state == HOLD && bus.instr_ready;
  assign expire = state == REQ && !bus.imem_ack && cnt == 8'(TIMEOUT - 1);
  instr_fetch_pc_next_logic #(.AW(AW), .PC_INC(PC_INC)) u_pc_next (
    .pc(pc),
    .pc_src(bus.pc_src),
    .branch_offset(bus.branch_offset),
    .pc_next(pc_next)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: an ack in the last allowed cycle beats the timeout
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? REQ : ack ? HOLD : expire ? ERR : commit ? REQ : state;
  end
  // PC, instruction register, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= AW'(RESET_PC);
      instr <= '0;
      instr_valid <= 1'b0;
      fetch_err <= 1'b0;
      cnt <= '0;
    end else begin
      if (ack) begin
        instr <= bus.imem_rdata;
        instr_valid <= 1'b1;
        cnt <= '0;
      end else if (state == REQ) cnt <= cnt + 8'd1;
      if (expire) fetch_err <= 1'b1;
      if (commit) begin
        instr_valid <= 1'b0;
        pc <= pc_next;
      end
    end
  end
  assign bus.imem_req = state == REQ;
  assign bus.imem_addr = pc;
  assign bus.pc = pc;
  assign bus.instr = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.fetch_err = fetch_err;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for the fetch stage, memory modelled by tasks
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_if #(.AW(8), .IW(16)) bus ();
  instr_fetch #(.AW(8), .IW(16), .RESET_PC(0), .PC_INC(1), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  logic [23:0] sb[$];
  logic [7:0] e_pc;
  logic [15:0] e_instr;
  localparam logic BR_SRC [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] BR_OFF [5] = '{8'h03, 8'hFD, 8'hFC, 8'h40, 8'h40};
  localparam logic [7:0] BR_ADR [5] = '{8'h05, 8'h02, 8'hFE, 8'hFF, 8'h00};

  // memory side: wait (bounded) for a request, stall, then ack and record the expectation
  task automatic serve(input int delay, input logic [15:0] data);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.imem_req === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL serve_req: imem_req=%b required 1", bus.imem_req);
    end else begin
      repeat (delay) @(negedge clk);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = data;
      sb.push_back({bus.imem_addr, data});
      @(negedge clk);
      bus.imem_ack = 1'b0;
    end
  endtask

  task automatic commit(input logic src, input logic [7:0] off);
    bus.instr_ready = 1'b1;
    bus.pc_src = src;
    bus.branch_offset = off;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.pc_src = 1'b0;
    bus.branch_offset = 8'h5A;
  endtask

  task automatic test_reset;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.pc_src = 1'b0;
    bus.branch_offset = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.pc !== 8'h00 || bus.instr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b err=%b pc=%h instr=%h required 0 0 0 00 0000",
               bus.imem_req, bus.instr_valid, bus.fetch_err, bus.pc, bus.instr);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1 00", bus.imem_req, bus.imem_addr);
    end
    serve(0, 16'h4123);
    checks++;
    if (bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_latency: instr_valid=%b required 1", bus.instr_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL reset_sb: scoreboard empty required 1 entry");
    end else begin
      {e_pc, e_instr} = sb.pop_front();
      if (bus.instr !== e_instr || bus.pc !== e_pc) begin
        errors++;
        $display("FAIL reset_instr: instr=%h pc=%h required %h %h", bus.instr, bus.pc, e_instr, e_pc);
      end
    end
  endtask

  task automatic test_sequential;
    commit(1'b0, 8'h77);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL seq_addr1: req=%b addr=%h required 1 01", bus.imem_req, bus.imem_addr);
    end
    serve(0, 16'h1111);
    checks++;
    if (sb.size() == 0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_valid1: instr_valid=%b required 1", bus.instr_valid);
    end else begin
      {e_pc, e_instr} = sb.pop_front();
      if (bus.instr !== e_instr || bus.pc !== e_pc) begin
        errors++;
        $display("FAIL seq_instr1: instr=%h pc=%h required %h %h", bus.instr, bus.pc, e_instr, e_pc);
      end
    end
    commit(1'b0, 8'h77);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h02 || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_wait%0d: req=%b addr=%h valid=%b required 1 02 0", i, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      @(negedge clk);
    end
    serve(0, 16'h2222);
    checks++;
    if (sb.size() == 0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_valid2: instr_valid=%b required 1", bus.instr_valid);
    end else begin
      {e_pc, e_instr} = sb.pop_front();
      if (bus.instr !== e_instr || bus.pc !== e_pc) begin
        errors++;
        $display("FAIL seq_instr2: instr=%h pc=%h required %h %h", bus.instr, bus.pc, e_instr, e_pc);
      end
    end
  endtask

  task automatic test_branch;
    for (int i = 0; i < 5; i++) begin
      commit(BR_SRC[i], BR_OFF[i]);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== BR_ADR[i]) begin
        errors++;
        $display("FAIL branch_addr%0d: req=%b addr=%h required 1 %h", i, bus.imem_req, bus.imem_addr, BR_ADR[i]);
      end
      serve(i, 16'hB000 | 16'(i));
      checks++;
      if (sb.size() == 0 || bus.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL branch_valid%0d: instr_valid=%b required 1", i, bus.instr_valid);
      end else begin
        {e_pc, e_instr} = sb.pop_front();
        if (bus.instr !== e_instr || bus.pc !== e_pc) begin
          errors++;
          $display("FAIL branch_instr%0d: instr=%h pc=%h required %h %h", i, bus.instr, bus.pc, e_instr, e_pc);
        end
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 4; i++) begin
      bus.instr_ready = 1'b0;
      bus.pc_src = i[0];
      bus.branch_offset = 8'($urandom);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (bus.instr !== e_instr || bus.pc !== e_pc || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: instr=%h pc=%h valid=%b req=%b required %h %h 1 0",
                 i, bus.instr, bus.pc, bus.instr_valid, bus.imem_req, e_instr, e_pc);
      end
    end
    bus.imem_ack = 1'b0;
    bus.pc_src = 1'b0;
  endtask

  task automatic test_timeout;
    commit(1'b0, 8'h10);
    for (int i = 1; i < 15; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_wait%0d: req=%b err=%b required 1 0", i, bus.imem_req, bus.fetch_err);
      end
      @(negedge clk);
    end
    serve(0, 16'hC0DE);
    checks++;
    if (sb.size() == 0 || bus.instr_valid !== 1'b1 || bus.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_last_ack: valid=%b err=%b required 1 0", bus.instr_valid, bus.fetch_err);
    end else begin
      {e_pc, e_instr} = sb.pop_front();
      if (bus.instr !== e_instr || bus.pc !== e_pc) begin
        errors++;
        $display("FAIL tmo_instr: instr=%h pc=%h required %h %h", bus.instr, bus.pc, e_instr, e_pc);
      end
    end
    commit(1'b0, 8'h10);
    repeat (14) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_edge: req=%b err=%b required 1 0", bus.imem_req, bus.fetch_err);
    end
    @(negedge clk);
    checks++;
    if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err: err=%b req=%b valid=%b required 1 0 0", bus.fetch_err, bus.imem_req, bus.instr_valid);
    end
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 8'h02) begin
      errors++;
      $display("FAIL tmo_sticky: err=%b req=%b valid=%b pc=%h required 1 0 0 02", bus.fetch_err, bus.imem_req, bus.instr_valid, bus.pc);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.fetch_err !== 1'b0 || bus.pc !== 8'h00 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_err: err=%b pc=%h req=%b required 0 00 0", bus.fetch_err, bus.pc, bus.imem_req);
    end
    serve(0, 16'h0A0A);
    if (sb.size() != 0) void'(sb.pop_front());
    commit(1'b1, 8'h20);
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h20) begin
      errors++;
      $display("FAIL rst_pre_req: req=%b addr=%h required 1 20", bus.imem_req, bus.imem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.pc !== 8'h00 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_req: pc=%h req=%b valid=%b err=%b required 00 0 0 0", bus.pc, bus.imem_req, bus.instr_valid, bus.fetch_err);
    end
    serve(1, 16'h3030);
    if (sb.size() != 0) void'(sb.pop_front());
    commit(1'b1, 8'h30);
    serve(0, 16'h5A5A);
    checks++;
    if (sb.size() == 0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_hold: valid=%b required 1", bus.instr_valid);
    end else begin
      {e_pc, e_instr} = sb.pop_front();
      if (bus.instr !== e_instr || bus.pc !== e_pc) begin
        errors++;
        $display("FAIL rst_pre_instr: instr=%h pc=%h required %h %h", bus.instr, bus.pc, e_instr, e_pc);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.pc !== 8'h00 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.instr !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_hold: pc=%h req=%b valid=%b err=%b instr=%h required 00 0 0 0 0000",
               bus.pc, bus.imem_req, bus.instr_valid, bus.fetch_err, bus.instr);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left required 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_branch;
    test_stall;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the single-cycle core, directly upstream of the control unit.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds the fetched instruction stable for the decoder and control unit.
- On the execute handshake, advances the PC sequentially or by branch offset, as selected by the control unit's PCSrc.

Parameters:
- AW, 8, PC/instruction-address width (bits)
- IW, 16, instruction width; opcode is instr[IW-1:IW-2]
- RESET_PC, 0, PC value after reset
- PC_INC, 1, sequential PC increment (word addressing)
- TIMEOUT, 15, maximum REQ cycles without ack before error (1..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  AW  fetch address (= pc)
- imem_ack  in  1  memory ack; imem_rdata valid in the same cycle
- imem_rdata  in  IW  instruction data
- instr  out  IW  held instruction to decode/control unit
- instr_valid  out  1  instr is valid and awaiting execution
- instr_ready  in  1  core executes instr this cycle (commit)
- pc_src  in  1  PCSrc from control unit: 1 = take branch
- branch_offset  in  AW  sign-extended offset from the immediate generator
- pc  out  AW  current PC (for PC-relative use downstream)
- fetch_err  out  1  sticky: memory failed to ack within TIMEOUT

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, timeout counter=0.
  - imem_req=0 during reset and in the first cycle after it.
- States: IDLE, REQ, HOLD, ERR. imem_req=(state==REQ); imem_addr=pc at all times.
- IDLE:
  - Go to REQ next cycle unconditionally.
- REQ:
  - imem_req=1 with imem_addr held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, counter<=0, go to HOLD.
  - Minimum latency: ack in the first REQ cycle gives instr_valid=1 on the next cycle.
  - Without ack: counter increments.
  - Counter reaches TIMEOUT-1 with no ack in that cycle: fetch_err<=1, go to ERR. An ack in that same cycle wins: normal HOLD, no error.
- HOLD:
  - instr and pc held constant while instr_valid=1.
  - On instr_ready=1: instr_valid<=0, go to REQ.
  - PC update on that same cycle: pc <= pc_src ? pc+branch_offset : pc+PC_INC.
  - pc_src and branch_offset are sampled only on this cycle and ignored otherwise.
- ERR:
  - imem_req=0, instr_valid=0; remains in ERR until rst.
- Throughput: at most one instruction per 2 cycles (REQ+HOLD).
- Arithmetic: PC sums are AW-bit, modulo 2^AW; wrap from 2^AW-1 to 0 is silent and not an error. branch_offset is two's complement, so negative offsets subtract.
- imem_ack outside REQ is ignored. instr_ready outside HOLD is ignored.
- Reset mid-request (REQ or HOLD): the pending request is abandoned and instr_valid drops on the reset edge.
- The PC is never modified outside the HOLD commit cycle.

Decomposition:
- Shared header fetch_defs.vh holds:
  - state encodings (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, ERR=2'd3)
  - opcode field position macros (OPC_HI=IW-1, OPC_LO=IW-2)
  - default PC_INC
- One sub-module, pc_next_logic: combinational next-PC mux and adder (pc, pc_src, branch_offset -> pc_next).
- The FSM, counter and instruction register stay in instr_fetch.

Test Plan:
- Reset then memory acks immediately with 16'h4123: imem_req=0 for the cycle after rst falls; req with addr 0; instr_valid=1 one cycle after ack; instr=16'h4123, pc=0.
- Sequential: instr_ready=1, pc_src=0 in HOLD -> next imem_addr=1, then 2; memory acks after 3 wait cycles -> addr stable and imem_req high throughout the wait.
- Branch: pc=5, pc_src=1, branch_offset=8'hFD (-3) at commit -> next imem_addr=2. Repeat with pc=8'hFE, pc_src=0 -> pc=8'hFF, then 8'h00 (wrap).
- Stall: instr_ready=0 for 4 cycles in HOLD -> instr, pc, instr_valid unchanged; toggling pc_src meanwhile has no effect; stray imem_ack ignored.
- Timeout: no ack for 15 REQ cycles -> fetch_err=1, imem_req=0, stays in ERR; ack arriving in exactly the 15th cycle -> no error, normal HOLD.
- Reset mid-REQ and mid-HOLD -> next cycle pc=RESET_PC, instr_valid=0, fetch_err=0, imem_req=0.
